// File: rtl/mitchell_pkg.sv
// Shared widths and the characteristic-to-shift helper for the Mitchell log multiplier.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Used by the log-encode, log-add and antilog blocks so every stage agrees on the
// operand width. Contents:
//   LOG2_WIDTH / WIDTH : operand width (WIDTH = 2**LOG2_WIDTH)
//   PROD_W             : linear product width (2*WIDTH)
//   SH_W               : width of a characteristic K and of a shift amount
//   shamt(k)           : returns {dir, sh}; dir=1 means left shift by sh
package mitchell_pkg;

    localparam int LOG2_WIDTH = 4;
    localparam int WIDTH      = 2 ** LOG2_WIDTH;
    localparam int PROD_W     = 2 * WIDTH;
    localparam int SH_W       = LOG2_WIDTH + 1;

    // The mantissa {1,X} carries an implied binary point WIDTH-1 places up,
    // so K=WIDTH-1 is the unshifted case; above it we shift left, below right.
    function automatic logic [SH_W:0] shamt(input logic [SH_W-1:0] k);
        logic [SH_W-1:0] c;
        logic            d;
        c = SH_W'(WIDTH - 1);
        d = (k >= c);
        return {d, (d ? (k - c) : (c - k))};
    endfunction

endpackage

// File: rtl/antilog_shifter.sv
// Bidirectional barrel shifter that turns mantissa {1,X} and {dir,sh} into the linear product.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline register decides when the result is taken.
//
// Ports:
//   i_m    : WIDTH-bit mantissa {1,X}
//   i_dir  : 1 = shift left, 0 = shift right
//   i_sh   : shift amount
//   i_zero : force the product to 0
//   o_p    : PROD_W-bit product
// Build option ANTILOG_ROUND_EN: when defined, right shifts add the last dropped
// bit (round half up); when undefined the dropped bits are truncated.
module antilog_shifter
    import mitchell_pkg::*;
(
    input  logic [WIDTH-1:0]  i_m,
    input  logic              i_dir,
    input  logic [SH_W-1:0]   i_sh,
    input  logic              i_zero,
    output logic [PROD_W-1:0] o_p
);

    logic [PROD_W-1:0] w_ext;
    logic [PROD_W-1:0] w_left;
    logic [PROD_W-1:0] w_right;
    logic [PROD_W-1:0] w_right_fin;

    assign w_ext   = PROD_W'(i_m);
    // Largest left shift is WIDTH, so m<<sh always fits in PROD_W bits.
    assign w_left  = w_ext << i_sh;
    assign w_right = w_ext >> i_sh;

`ifdef ANTILOG_ROUND_EN
    logic w_rbit;
    // Bit sh-1 of m is the first bit dropped by the right shift. Gated on sh!=0
    // because sh-1 wraps for sh=0. The increment cannot carry out: the largest
    // right-shift result is below 2**WIDTH.
    assign w_rbit      = !i_dir && (i_sh != '0) &&
                         (|(w_ext & (PROD_W'(1) << (i_sh - SH_W'(1)))));
    assign w_right_fin = w_right + PROD_W'(w_rbit);
`else
    assign w_right_fin = w_right;
`endif

    assign o_p = i_zero ? '0 : (i_dir ? w_left : w_right_fin);

endmodule

// File: rtl/mitchell_antilog.sv
// Antilog decode stage: rebuilds P = {1,X} * 2^K / 2^(WIDTH-1) from characteristic K and fraction X.
// Latency: 2 cycles from input accept to out_valid; one beat per cycle when out_ready stays high.
// Backpressure: valid/ready; a stalled output holds, S1 holds, in_ready drops once S1 is also full.
//
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_zero/in_k/in_x input beat,
//        out_valid/out_ready/out_p/out_zero product beat.
// Widths come from mitchell_pkg so encode, add and decode stay consistent.
// Build option ANTILOG_ROUND_EN selects round-half-up on right shifts (see antilog_shifter).
module mitchell_antilog
    import mitchell_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [SH_W-1:0]   in_k,
    input  logic [WIDTH-2:0]  in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic              out_zero
);

    // S1: decoded shift request
    logic              r_s1_valid;
    logic              r_s1_zero;
    logic [WIDTH-1:0]  r_s1_m;
    logic              r_s1_dir;
    logic [SH_W-1:0]   r_s1_sh;

    // S2: product
    logic              r_out_valid;
    logic [PROD_W-1:0] r_out_p;
    logic              r_out_zero;

    logic              w_s2_accept;
    logic [SH_W:0]     w_shamt;
    logic [PROD_W-1:0] w_p;

    assign w_s2_accept = !r_out_valid || out_ready;
    // Depends only on registered state and out_ready, never on in_valid.
    assign in_ready    = !r_s1_valid || w_s2_accept;
    assign w_shamt     = shamt(in_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_m     <= '0;
            r_s1_dir   <= 1'b0;
            r_s1_sh    <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_zero <= in_zero;
                r_s1_m    <= {1'b1, in_x};
                r_s1_dir  <= w_shamt[SH_W];
                r_s1_sh   <= w_shamt[SH_W-1:0];
            end
        end
    end

    antilog_shifter u_shifter (
        .i_m    (r_s1_m),
        .i_dir  (r_s1_dir),
        .i_sh   (r_s1_sh),
        .i_zero (r_s1_zero),
        .o_p    (w_p)
    );

    // S2 loads whenever it is empty or being drained, so a drain and a fill in
    // the same cycle move exactly one beat forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_s2_accept) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_p    <= w_p;
                r_out_zero <= r_s1_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_mitchell_antilog.sv
// Self-checking bench for mitchell_antilog (WIDTH=16).
// Latency: n/a.
// Backpressure: out_ready driven by fixed patterns and randomly.
module tb_mitchell_antilog;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_zero;
    logic [4:0]  in_k;
    logic [14:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        out_zero;

    mitchell_antilog dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_zero   (in_zero),
        .in_k      (in_k),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];   // {zero, product}
    logic        mon_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision m*2^k, then drop the 15 fraction bits.
    function automatic logic [32:0] model(input logic z, input logic [4:0] k, input logic [14:0] x);
        logic [63:0] v;
        logic [63:0] p;
        if (z) return {1'b1, 32'd0};
        v = {48'd0, 1'b1, x} << k;
        p = v >> 15;
`ifdef ANTILOG_ROUND_EN
        if (k < 5'd15) p = p + {63'd0, v[14]};
`endif
        return {1'b0, p[31:0]};
    endfunction

    // Output monitor: compares every transferred beat and checks hold-while-stalled.
    logic        prev_stall = 1'b0;
    logic [32:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", {63'd0, out_valid}, 64'd1);
                chk("stall_hold", {31'd0, out_zero, out_p}, {31'd0, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", {31'd0, out_zero, out_p}, 64'hDEAD);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("out_p", {32'd0, out_p}, {32'd0, e[31:0]});
                    chk("out_zero", {63'd0, out_zero}, {63'd0, e[32]});
                end
            end
            prev_stall <= out_valid && !out_ready;
            held       <= {out_zero, out_p};
        end
    end

    task automatic send(input logic z, input logic [4:0] k, input logic [14:0] x);
        in_valid = 1'b1;
        in_zero  = z;
        in_k     = k;
        in_x     = x;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(z, k, x));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", exp_q.size(), 64'd0);
        exp_q.delete();
    endtask

    bit rnd_done;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_zero   = 1'b0;
        in_k      = '0;
        in_x      = '0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        rnd_done  = 1'b0;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_p", {32'd0, out_p}, 64'd0);
        chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: K=0,X=0 -> 1, output appears on the second edge after accept
        send(1'b0, 5'd0, 15'h0000);
        @(negedge clk);
        chk("lat_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_vld", {63'd0, out_valid}, 64'd1);
        chk("t1_p", {32'd0, out_p}, 64'h1);
        drain();

        // 2, 3, 4: directed values
        send(1'b0, 5'd3, 15'h4000);
        drain();
        chk("t2_p", {32'd0, out_p}, 64'hC);
        send(1'b0, 5'd31, 15'h7FFF);
        drain();
        chk("t3_p", {32'd0, out_p}, 64'hFFFF0000);
        send(1'b0, 5'd0, 15'h4000);
        drain();
`ifdef ANTILOG_ROUND_EN
        chk("t4_round", {32'd0, out_p}, 64'h2);
`else
        chk("t4_trunc", {32'd0, out_p}, 64'h1);
`endif
        send(1'b0, 5'd15, 15'h1234);   // sh=0: P = m
        drain();
        chk("k15_p", {32'd0, out_p}, 64'h9234);

        // 5: back-to-back beats with out_ready 1,0,0,1 repeating
        fork
            begin
                for (int i = 0; i < 8; i++) send(1'b0, 5'(10 + i), 15'(i * 4099));
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // in_ready drops once both stages hold a stalled beat
        out_ready = 1'b0;
        send(1'b0, 5'd20, 15'h0ABC);
        send(1'b0, 5'd7, 15'h5555);
        @(negedge clk);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Random traffic under random backpressure
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send($urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)), 15'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // 6: zero operand, then reset mid-stream
        send(1'b1, 5'd20, 15'h7777);
        drain();
        chk("t6_p", {32'd0, out_p}, 64'd0);
        chk("t6_zero", {63'd0, out_zero}, 64'd1);
        out_ready = 1'b0;
        send(1'b0, 5'd18, 15'h0101);
        send(1'b0, 5'd19, 15'h0202);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_p", {32'd0, out_p}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("post_rst_quiet", seen, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
